// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Bubbles on flush or load-use, freezes on hold, counts load-use bubbles.
module id_ex_hazard_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_id_valid,
  input  logic [XLEN-1:0] i_id_pc,
  input  logic [4:0]      i_id_rs1,
  input  logic [4:0]      i_id_rs2,
  input  logic            i_id_rs1_used,
  input  logic            i_id_rs2_used,
  input  logic [4:0]      i_id_rd,
  input  logic [XLEN-1:0] i_id_rs1_data,
  input  logic [XLEN-1:0] i_id_rs2_data,
  input  logic [XLEN-1:0] i_id_imm,
  input  logic [3:0]      i_id_alu_op,
  input  logic            i_id_regwrite,
  input  logic            i_id_memread,
  input  logic            i_id_memwrite,
  input  logic [1:0]      i_id_wb_sel,
  input  logic            i_flush,
  input  logic            i_hold,
  output logic            o_stall_fd,
  output logic            o_idex_valid,
  output logic [XLEN-1:0] o_idex_pc,
  output logic [4:0]      o_idex_rs1,
  output logic [4:0]      o_idex_rs2,
  output logic [4:0]      o_idex_rd,
  output logic [XLEN-1:0] o_idex_rs1_data,
  output logic [XLEN-1:0] o_idex_rs2_data,
  output logic [XLEN-1:0] o_idex_imm,
  output logic [3:0]      o_idex_alu_op,
  output logic            o_idex_regwrite,
  output logic            o_idex_memread,
  output logic            o_idex_memwrite,
  output logic [1:0]      o_idex_wb_sel,
  output logic [CNT_W-1:0] o_lu_stall_cnt
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic [1:0]      wb_sel;
  } id_ex_t;

  id_ex_t          idex_q;
  id_ex_t          idex_d;
  id_ex_t          id_in;
  logic [CNT_W-1:0] cnt_q;
  logic            rs1_hit;
  logic            rs2_hit;
  logic            lu;
  logic            lu_take;

  // Pack ID fields; an invalid slot must never write state downstream
  always_comb begin
    id_in          = '0;
    id_in.valid    = i_id_valid;
    id_in.pc       = i_id_pc;
    id_in.rs1      = i_id_rs1;
    id_in.rs2      = i_id_rs2;
    id_in.rd       = i_id_rd;
    id_in.rs1_data = i_id_rs1_data;
    id_in.rs2_data = i_id_rs2_data;
    id_in.imm      = i_id_imm;
    id_in.alu_op   = i_id_alu_op;
    id_in.regwrite = i_id_regwrite & i_id_valid;
    id_in.memread  = i_id_memread  & i_id_valid;
    id_in.memwrite = i_id_memwrite & i_id_valid;
    id_in.wb_sel   = i_id_wb_sel;
  end

  // Load in EX whose rd is read by the instruction in ID
  always_comb begin
    rs1_hit = i_id_rs1_used & (i_id_rs1 == idex_q.rd);
    rs2_hit = i_id_rs2_used & (i_id_rs2 == idex_q.rd);
    lu      = idex_q.valid & idex_q.memread
            & (idex_q.rd != 5'd0) & i_id_valid
            & (rs1_hit | rs2_hit);
    lu_take = lu & ~i_flush & ~i_hold;
  end

  assign o_stall_fd = ~i_flush & (i_hold | lu);

  // Next-state selection: flush, hold, load-use bubble, then advance
  always_comb begin
    idex_d = id_in;
    if (i_flush)
      idex_d = '0;
    else if (i_hold)
      idex_d = idex_q;
    else if (lu)
      idex_d = '0;
  end

  // Pipeline register and load-use bubble counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      idex_q <= '0;
      cnt_q  <= '0;
    end else begin
      idex_q <= idex_d;
      if (lu_take)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_idex_valid    = idex_q.valid;
  assign o_idex_pc       = idex_q.pc;
  assign o_idex_rs1      = idex_q.rs1;
  assign o_idex_rs2      = idex_q.rs2;
  assign o_idex_rd       = idex_q.rd;
  assign o_idex_rs1_data = idex_q.rs1_data;
  assign o_idex_rs2_data = idex_q.rs2_data;
  assign o_idex_imm      = idex_q.imm;
  assign o_idex_alu_op   = idex_q.alu_op;
  assign o_idex_regwrite = idex_q.regwrite;
  assign o_idex_memread  = idex_q.memread;
  assign o_idex_memwrite = idex_q.memwrite;
  assign o_idex_wb_sel   = idex_q.wb_sel;
  assign o_lu_stall_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Bench for id_ex_hazard_reg: random and directed stimulus
// checked against a rule-level model of the ID/EX register.
module tb_id_ex_hazard_reg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic            clk;
  logic            rst_n;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_rs1_used;
  logic            id_rs2_used;
  logic [4:0]      id_rd;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [3:0]      id_alu_op;
  logic            id_regwrite;
  logic            id_memread;
  logic            id_memwrite;
  logic [1:0]      id_wb_sel;
  logic            flush;
  logic            hold;
  logic            stall_fd;
  logic            q_valid;
  logic [XLEN-1:0] q_pc;
  logic [4:0]      q_rs1;
  logic [4:0]      q_rs2;
  logic [4:0]      q_rd;
  logic [XLEN-1:0] q_rs1_data;
  logic [XLEN-1:0] q_rs2_data;
  logic [XLEN-1:0] q_imm;
  logic [3:0]      q_alu_op;
  logic            q_regwrite;
  logic            q_memread;
  logic            q_memwrite;
  logic [1:0]      q_wb_sel;
  logic [CNT_W-1:0] lu_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  // Model of the architectural ID/EX contents
  typedef struct {
    bit       valid;
    int unsigned pc, d1, d2, imm;
    int       rs1, rs2, rd, alu, wb;
    bit       rw, mr, mw;
  } slot_t;

  slot_t m;
  int    m_cnt;

  id_ex_hazard_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_id_valid(id_valid), .i_id_pc(id_pc),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_rs1_used(id_rs1_used), .i_id_rs2_used(id_rs2_used),
    .i_id_rd(id_rd),
    .i_id_rs1_data(id_rs1_data), .i_id_rs2_data(id_rs2_data),
    .i_id_imm(id_imm), .i_id_alu_op(id_alu_op),
    .i_id_regwrite(id_regwrite), .i_id_memread(id_memread),
    .i_id_memwrite(id_memwrite), .i_id_wb_sel(id_wb_sel),
    .i_flush(flush), .i_hold(hold),
    .o_stall_fd(stall_fd),
    .o_idex_valid(q_valid), .o_idex_pc(q_pc),
    .o_idex_rs1(q_rs1), .o_idex_rs2(q_rs2), .o_idex_rd(q_rd),
    .o_idex_rs1_data(q_rs1_data), .o_idex_rs2_data(q_rs2_data),
    .o_idex_imm(q_imm), .o_idex_alu_op(q_alu_op),
    .o_idex_regwrite(q_regwrite), .o_idex_memread(q_memread),
    .o_idex_memwrite(q_memwrite), .o_idex_wb_sel(q_wb_sel),
    .o_lu_stall_cnt(lu_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Does the model's EX load feed a register ID reads?
  function automatic bit model_lu();
    bit dep;
    dep = (id_rs1_used && id_rs1 == m.rd)
       || (id_rs2_used && id_rs2 == m.rd);
    return m.valid && m.mr && m.rd != 0 && id_valid && dep;
  endfunction

  task automatic check_outputs();
    check("valid", 64'(q_valid), 64'(m.valid));
    check("pc", 64'(q_pc), 64'(m.pc));
    check("rs1", 64'(q_rs1), 64'(m.rs1));
    check("rs2", 64'(q_rs2), 64'(m.rs2));
    check("rd", 64'(q_rd), 64'(m.rd));
    check("rs1_data", 64'(q_rs1_data), 64'(m.d1));
    check("rs2_data", 64'(q_rs2_data), 64'(m.d2));
    check("imm", 64'(q_imm), 64'(m.imm));
    check("alu_op", 64'(q_alu_op), 64'(m.alu));
    check("regwrite", 64'(q_regwrite), 64'(m.rw));
    check("memread", 64'(q_memread), 64'(m.mr));
    check("memwrite", 64'(q_memwrite), 64'(m.mw));
    check("wb_sel", 64'(q_wb_sel), 64'(m.wb));
    check("lu_cnt", 64'(lu_cnt), 64'(m_cnt));
  endtask

  // Apply one clock with current inputs and compare to the model
  task automatic cycle();
    slot_t nx;
    bit    lu;
    #1;
    lu = model_lu();
    check("stall_fd", 64'(stall_fd), 64'(!flush && (hold || lu)));
    nx = m;
    if (!rst_n || flush || (!hold && lu)) begin
      nx = '{default: 0};
    end else if (!hold) begin
      nx.valid = id_valid;
      nx.pc = id_pc; nx.d1 = id_rs1_data;
      nx.d2 = id_rs2_data; nx.imm = id_imm;
      nx.rs1 = id_rs1; nx.rs2 = id_rs2; nx.rd = id_rd;
      nx.alu = id_alu_op; nx.wb = id_wb_sel;
      nx.rw = id_valid && id_regwrite;
      nx.mr = id_valid && id_memread;
      nx.mw = id_valid && id_memwrite;
    end
    if (!rst_n) m_cnt = 0;
    else if (lu && !flush && !hold) m_cnt = (m_cnt + 1) % 16;
    @(posedge clk);
    #1;
    m = nx;
    check_outputs();
  endtask

  task automatic rand_data();
    id_pc = $urandom; id_imm = $urandom;
    id_rs1_data = $urandom; id_rs2_data = $urandom;
    id_alu_op = 4'($urandom); id_wb_sel = 2'($urandom);
    id_memwrite = 1'($urandom);
  endtask

  task automatic set_id(input bit v, input int r1, input bit u1,
                        input int r2, input bit u2,
                        input int rd, input bit mr);
    rand_data();
    id_valid = v;
    id_rs1 = 5'(r1); id_rs1_used = u1;
    id_rs2 = 5'(r2); id_rs2_used = u2;
    id_rd = 5'(rd); id_memread = mr;
    id_regwrite = 1'b1;
    if (mr) id_memwrite = 1'b0;
  endtask

  task automatic rand_all();
    rand_data();
    id_valid = ($urandom_range(0, 7) != 0);
    id_rs1 = 5'($urandom_range(0, 3));
    id_rs2 = 5'($urandom_range(0, 3));
    id_rd  = 5'($urandom_range(0, 3));
    id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
    id_regwrite = 1'($urandom);
    id_memread = ($urandom_range(0, 1) == 0);
    flush = ($urandom_range(0, 9) == 0);
    hold  = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    m = '{default: 0};
    m_cnt = 0;
    rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
    set_id(1, 1, 1, 2, 1, 3, 1);
    // Reset with random inputs
    repeat (2) begin
      rand_all();
      cycle();
    end
    rst_n = 1'b1; flush = 1'b0; hold = 1'b0;
    // Load-use on rs1
    set_id(1, 0, 0, 0, 0, 5, 1);
    cycle();
    set_id(1, 5, 1, 9, 1, 6, 0);
    cycle();
    check("lu_bubble_valid", 64'(q_valid), 64'd0);
    check("lu_cnt_one", 64'(lu_cnt), 64'd1);
    cycle();
    check("lu_dep_rs1", 64'(q_rs1), 64'd5);
    // lw x0 never stalls
    set_id(1, 0, 0, 0, 0, 0, 1);
    cycle();
    set_id(1, 0, 1, 0, 1, 4, 0);
    cycle();
    check("x0_no_bubble", 64'(q_valid), 64'd1);
    // Unused rs2 match does not stall
    set_id(1, 0, 0, 0, 0, 7, 1);
    cycle();
    set_id(1, 1, 1, 7, 0, 8, 0);
    cycle();
    check("unused_rs2", 64'(q_rd), 64'd8);
    // Flush beats load-use
    set_id(1, 0, 0, 0, 0, 9, 1);
    cycle();
    set_id(1, 9, 1, 9, 1, 10, 0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_cnt", 64'(lu_cnt), 64'd1);
    // Hold three cycles with ID changing, hazard pending
    set_id(1, 0, 0, 0, 0, 11, 1);
    cycle();
    hold = 1'b1;
    repeat (3) begin
      set_id(1, 11, 1, 11, 1, 12, 0);
      id_rs1 = 5'($urandom_range(11, 12));
      cycle();
    end
    check("hold_rd", 64'(q_rd), 64'd11);
    hold = 1'b0;
    set_id(1, 2, 1, 3, 1, 13, 0);
    cycle();
    check("release_load", 64'(q_rd), 64'd13);
    // Sixteen load-use bubbles wrap the 4-bit counter
    for (int i = 0; i < 16; i++) begin
      set_id(1, 0, 0, 0, 0, 3, 1);
      cycle();
      set_id(1, 3, 1, 3, 1, 4, 0);
      cycle();
    end
    check("cnt_wrap", 64'(lu_cnt), 64'd1);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_all();
      rst_n = ($urandom_range(0, 99) != 0);
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
